pc_npc_sequencer: RTL and testbench
===================================

// Module: pc_npc_sequencer
// PURPOSE
//  Sequences the 9-bit PC/nPC register pair of the MIPS fetch stage. Issues synchronous
//  init, load enables and next values (pc_d/npc_d) each cycle. Implements the
//  delayed-branch rule PC<=nPC, nPC<=target|nPC+4. Holds redirects raised during a stall
//  until fetch advances. Sits between hazard/branch logic and the PC/nPC registers.
// PARAMETERS
//  AW      9  address width of PC/nPC
//  STEP    4  increment added to nPC per advance (bytes/instruction)
// PORTS
//  Clk          in   1   clock, all state on rising edge
//  Reset_n      in   1   asynchronous active-low reset
//  pc_q         in   AW  current PC register output
//  npc_q        in   AW  current nPC register output
//  stall        in   1   hazard stall; 1 = hold PC/nPC
//  imem_ready   in   1   instruction memory accepts fetch this cycle
//  redir_req    in   1   branch taken / jump, one-cycle pulse
//  redir_tgt    in   AW  redirect target address
//  halt         in   1   stop fetching until next reset
//  regs_rst     out  1   synchronous reset to PC/nPC registers (PC->0, nPC->4)
//  pc_ld        out  1   PC load enable
//  npc_ld       out  1   nPC load enable
//  pc_d         out  AW  PC next value
//  npc_d        out  AW  nPC next value
//  fetch_valid  out  1   PC holds a valid fetch address this cycle
//  err_slot     out  1   sticky: redirect arrived while one was pending
//  err_align    out  1   sticky: redirect target low 2 bits nonzero
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=INIT, pend=0, err_*=0, pc_ld=npc_ld=0, fetch_valid=0,
//   regs_rst=1, pc_d=npc_d=0.
//  FSM states INIT, RUN, STALL, HALT (registered):
//   INIT : regs_rst=1 for exactly one Clk after Reset_n rises; -> RUN.
//   RUN  : fetch_valid=1. advance = !stall & imem_ready. If advance: pc_ld=npc_ld=1,
//          pc_d=npc_q, npc_d = (pend|redir_req) ? tgt : npc_q+STEP.
//          If !advance -> STALL.
//   STALL: ld=0, fetch_valid=1 (same address); -> RUN when stall=0 & imem_ready=1
//          (the advance itself happens in RUN on the following cycle).
//   HALT : entered from any non-INIT state when halt=1 at an edge; all ld=0,
//          fetch_valid=0; exit only via Reset_n. halt wins over every other event.
//  Redirect capture: redir_req in a non-advancing cycle sets pend=1, pend_tgt=redir_tgt.
//   pend consumed (cleared) by the next advance; redir_req in the advancing cycle is used
//   directly (latency 0: target appears in nPC at the edge ending that cycle, in PC one
//   advance later -> exactly one delay-slot instruction).
//  Second redirect while pend=1 (or redir_req in the advance that consumes pend): ignored,
//   err_slot<=1; first target wins.
//  Alignment: target used with bits[1:0] forced to 0; err_align<=1 if they were nonzero.
//  Arithmetic: npc_q+STEP modulo 2^AW (0x1FC+4 -> 0x000), no flag.
//  pc_d/npc_d are don't-care when ld=0 but must be driven (hold pc_q/npc_q).
//  Reset_n asserted mid-stall or with pend=1: everything cleared, re-enters INIT.
// TESTING
//  1 Reset release, stall=0, ready=1 -> regs_rst 1 cycle; PC 0,4,8,C; nPC 4,8,C,10.
//  2 redir_req tgt=0x40 while PC=8,nPC=C -> next PC=C,nPC=40; then PC=40,nPC=44.
//  3 stall=1 3 cycles, redir_req tgt=0x80 in 2nd stall cycle -> no ld during stall;
//    first advance loads nPC=0x80; pend clears.
//  4 Second redir_req (tgt=0x90) while pend(0x80) -> 0x80 used, err_slot=1 sticky.
//  5 nPC=0x1FC advance -> nPC=0x000; tgt=0x43 -> nPC=0x40, err_align=1.
//  6 halt at PC=0x10 -> fetch_valid=0, ld=0 forever; Reset_n pulse mid-halt -> INIT, PC=0.

Source files
------------

// File: rtl/pc_npc_sequencer.sv
// Control sequencer for the fetch-stage PC/nPC register pair: delayed-branch update,
// stall hold with redirect capture, halt, and sticky redirect error flags.
module pc_npc_sequencer #(
    parameter int AW   = 9,
    parameter int STEP = 4
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic [AW-1:0] pc_q,
    input  logic [AW-1:0] npc_q,
    input  logic          stall,
    input  logic          imem_ready,
    input  logic          redir_req,
    input  logic [AW-1:0] redir_tgt,
    input  logic          halt,
    output logic          regs_rst,
    output logic          pc_ld,
    output logic          npc_ld,
    output logic [AW-1:0] pc_d,
    output logic [AW-1:0] npc_d,
    output logic          fetch_valid,
    output logic          err_slot,
    output logic          err_align
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    localparam logic [AW-1:0] STEP_W = AW'(STEP);

    state_e        state_q;
    logic          regs_rst_q;
    logic          fetch_valid_q;
    logic          pend_q;
    logic [AW-1:0] pend_tgt_q;
    logic          err_slot_q;
    logic          err_align_q;

    logic          active_s;
    logic          go_s;
    logic          advance_s;
    logic          hold_s;
    logic          misal_s;
    logic [AW-1:0] tgt_al_s;

    // halt suppresses loads and redirect capture in the cycle it is raised
    assign active_s  = (state_q == ST_RUN) || (state_q == ST_STALL);
    assign go_s      = !stall && imem_ready;
    assign advance_s = (state_q == ST_RUN) && go_s && !halt;
    assign hold_s    = active_s && !halt && !advance_s;
    assign tgt_al_s  = {redir_tgt[AW-1:2], 2'b00};
    assign misal_s   = (redir_tgt[1:0] != 2'b00);

    // Sequencer FSM with registered regs_rst / fetch_valid
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= ST_INIT;
            regs_rst_q    <= 1'b1;
            fetch_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_q       <= ST_RUN;
                    regs_rst_q    <= 1'b0;
                    fetch_valid_q <= 1'b1;
                end
                ST_RUN: begin
                    regs_rst_q <= 1'b0;
                    if (halt) begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                    end else if (!go_s) begin
                        state_q       <= ST_STALL;
                        fetch_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_STALL: begin
                    regs_rst_q <= 1'b0;
                    if (halt) begin
                        state_q       <= ST_HALT;
                        fetch_valid_q <= 1'b0;
                    end else if (go_s) begin
                        state_q       <= ST_RUN;
                        fetch_valid_q <= 1'b1;
                    end else begin
                        state_q       <= ST_STALL;
                        fetch_valid_q <= 1'b1;
                    end
                end
                ST_HALT: begin
                    state_q       <= ST_HALT;
                    regs_rst_q    <= 1'b0;
                    fetch_valid_q <= 1'b0;
                end
                default: begin
                    state_q       <= ST_INIT;
                    regs_rst_q    <= 1'b1;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Pending redirect and sticky error flags; the first redirect always wins
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pend_q      <= 1'b0;
            pend_tgt_q  <= '0;
            err_slot_q  <= 1'b0;
            err_align_q <= 1'b0;
        end else if (advance_s) begin
            pend_q <= 1'b0;
            if (redir_req && pend_q) begin
                err_slot_q <= 1'b1;
            end else if (redir_req && misal_s) begin
                err_align_q <= 1'b1;
            end else begin
                err_slot_q <= err_slot_q;
            end
        end else if (hold_s && redir_req) begin
            if (pend_q) begin
                err_slot_q <= 1'b1;
            end else begin
                pend_q     <= 1'b1;
                pend_tgt_q <= tgt_al_s;
                if (misal_s) begin
                    err_align_q <= 1'b1;
                end else begin
                    err_align_q <= err_align_q;
                end
            end
        end else begin
            pend_q <= pend_q;
        end
    end

    // Load enables and next values; loads happen only on an advance in RUN
    always_comb begin
        pc_ld  = advance_s;
        npc_ld = advance_s;
        pc_d   = pc_q;
        npc_d  = npc_q;
        if (state_q == ST_INIT) begin
            pc_d  = '0;
            npc_d = '0;
        end else if (advance_s) begin
            pc_d = npc_q;
            if (pend_q) begin
                npc_d = pend_tgt_q;
            end else if (redir_req) begin
                npc_d = tgt_al_s;
            end else begin
                npc_d = npc_q + STEP_W;
            end
        end else begin
            pc_d  = pc_q;
            npc_d = npc_q;
        end
    end

    assign regs_rst    = regs_rst_q;
    assign fetch_valid = fetch_valid_q;
    assign err_slot    = err_slot_q;
    assign err_align   = err_align_q;

endmodule

// File: tb/tb_pc_npc_sequencer.sv
// Bench for pc_npc_sequencer: models the PC/nPC registers and scoreboards
// per-cycle load enables, register contents, fetch_valid and error flags.
module tb_pc_npc_sequencer;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [8:0] pc_reg  = 9'h155;
    logic [8:0] npc_reg = 9'h0AA;
    logic       stall, imem_ready, redir_req, halt;
    logic [8:0] redir_tgt;
    logic       regs_rst, pc_ld, npc_ld, fetch_valid, err_slot, err_align;
    logic [8:0] pc_d, npc_d;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    typedef struct {
        logic       ld;
        logic       rr;
        logic [8:0] pc;
        logic [8:0] npc;
        logic       fv;
        logic       es;
        logic       ea;
    } exp_t;

    exp_t sb_q[$];

    pc_npc_sequencer #(.AW(9), .STEP(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .pc_q(pc_reg), .npc_q(npc_reg),
        .stall(stall), .imem_ready(imem_ready), .redir_req(redir_req),
        .redir_tgt(redir_tgt), .halt(halt), .regs_rst(regs_rst),
        .pc_ld(pc_ld), .npc_ld(npc_ld), .pc_d(pc_d), .npc_d(npc_d),
        .fetch_valid(fetch_valid), .err_slot(err_slot), .err_align(err_align)
    );

    always #5 Clk = ~Clk;

    // PC/nPC register pair driven by the sequencer
    always @(posedge Clk) begin
        if (regs_rst) begin
            pc_reg  <= 9'h000;
            npc_reg <= 9'h004;
        end else begin
            if (pc_ld)  pc_reg  <= pc_d;
            if (npc_ld) npc_reg <= npc_d;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives one cycle and returns at the following negedge
    task automatic cyc(input logic st, input logic rdy, input logic rq,
                       input logic [8:0] tgt, input logic hl, input exp_t e);
        exp_t it;
        logic ld_o, nld_o, rr_o;
        stall = st; imem_ready = rdy; redir_req = rq; redir_tgt = tgt; halt = hl;
        sb_q.push_back(e);
        #1;
        ld_o = pc_ld; nld_o = npc_ld; rr_o = regs_rst;
        @(negedge Clk);
        it = sb_q.pop_front();
        check_val($sformatf("c%0d_pc_ld", cyc_n), {31'd0, ld_o}, {31'd0, it.ld});
        check_val($sformatf("c%0d_npc_ld", cyc_n), {31'd0, nld_o}, {31'd0, it.ld});
        check_val($sformatf("c%0d_regs_rst", cyc_n), {31'd0, rr_o}, {31'd0, it.rr});
        check_val($sformatf("c%0d_pc", cyc_n), {23'd0, pc_reg}, {23'd0, it.pc});
        check_val($sformatf("c%0d_npc", cyc_n), {23'd0, npc_reg}, {23'd0, it.npc});
        check_val($sformatf("c%0d_fetch_valid", cyc_n), {31'd0, fetch_valid}, {31'd0, it.fv});
        check_val($sformatf("c%0d_err_slot", cyc_n), {31'd0, err_slot}, {31'd0, it.es});
        check_val($sformatf("c%0d_err_align", cyc_n), {31'd0, err_align}, {31'd0, it.ea});
        cyc_n++;
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_regs_rst"}, {31'd0, regs_rst}, 32'd1);
        check_val({tag, "_pc_ld"}, {31'd0, pc_ld}, 32'd0);
        check_val({tag, "_npc_ld"}, {31'd0, npc_ld}, 32'd0);
        check_val({tag, "_pc_d"}, {23'd0, pc_d}, 32'd0);
        check_val({tag, "_npc_d"}, {23'd0, npc_d}, 32'd0);
        check_val({tag, "_fetch_valid"}, {31'd0, fetch_valid}, 32'd0);
        check_val({tag, "_err_slot"}, {31'd0, err_slot}, 32'd0);
        check_val({tag, "_err_align"}, {31'd0, err_align}, 32'd0);
    endtask

    initial begin
        Reset_n = 1'b0;
        stall = 1'b0; imem_ready = 1'b1; redir_req = 1'b0; redir_tgt = 9'h000; halt = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_reset_state("rst0");
        Reset_n = 1'b1;

        // release, linear advance
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b1, 9'h000, 9'h004, 1'b1, 1'b0, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h004, 9'h008, 1'b1, 1'b0, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h008, 9'h00C, 1'b1, 1'b0, 1'b0});
        // redirect with one delay slot
        cyc(1'b0, 1'b1, 1'b1, 9'h040, 1'b0, '{1'b1, 1'b0, 9'h00C, 9'h040, 1'b1, 1'b0, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h040, 9'h044, 1'b1, 1'b0, 1'b0});
        // stall with captured redirect, second redirect flagged
        cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b0, 9'h040, 9'h044, 1'b1, 1'b0, 1'b0});
        cyc(1'b1, 1'b1, 1'b1, 9'h080, 1'b0, '{1'b0, 1'b0, 9'h040, 9'h044, 1'b1, 1'b0, 1'b0});
        cyc(1'b1, 1'b1, 1'b1, 9'h090, 1'b0, '{1'b0, 1'b0, 9'h040, 9'h044, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b0, 9'h040, 9'h044, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h044, 9'h080, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h080, 9'h084, 1'b1, 1'b1, 1'b0});
        // memory not ready
        cyc(1'b0, 1'b0, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b0, 9'h080, 9'h084, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b0, 9'h080, 9'h084, 1'b1, 1'b1, 1'b0});
        // wrap at top of address space, misaligned target
        cyc(1'b0, 1'b1, 1'b1, 9'h1F8, 1'b0, '{1'b1, 1'b0, 9'h084, 9'h1F8, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h1F8, 9'h1FC, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h1FC, 9'h000, 1'b1, 1'b1, 1'b0});
        cyc(1'b0, 1'b1, 1'b1, 9'h043, 1'b0, '{1'b1, 1'b0, 9'h000, 9'h040, 1'b1, 1'b1, 1'b1});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h040, 9'h044, 1'b1, 1'b1, 1'b1});
        // reach PC=0x10 then halt
        cyc(1'b0, 1'b1, 1'b1, 9'h010, 1'b0, '{1'b1, 1'b0, 9'h044, 9'h010, 1'b1, 1'b1, 1'b1});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h010, 9'h014, 1'b1, 1'b1, 1'b1});
        cyc(1'b1, 1'b1, 1'b0, 9'h000, 1'b1, '{1'b0, 1'b0, 9'h010, 9'h014, 1'b0, 1'b1, 1'b1});
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 9'h020, 1'b0, '{1'b0, 1'b0, 9'h010, 9'h014, 1'b0, 1'b1, 1'b1});
        end
        // reset pulse while halted
        Reset_n = 1'b0;
        #2;
        check_reset_state("rst1");
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b0, 1'b1, 9'h000, 9'h004, 1'b1, 1'b0, 1'b0});
        cyc(1'b0, 1'b1, 1'b0, 9'h000, 1'b0, '{1'b1, 1'b0, 9'h004, 9'h008, 1'b1, 1'b0, 1'b0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
